// File: rtl/vram_ctrl.sv
// vram_ctrl: character-cell frame RAM for the VGA scan-out path.
//
// Holds WORDS 32-bit words (four cells per word, byte 0 = leftmost cell).
// The CPU reads and writes with byte masks. The VGA block reads through its
// own port. A fill engine clears or fills the whole frame after reset and on
// CPU command.
//
// Ports
//   clk    : system clock shared by the CPU and VGA sides
//   reset  : synchronous, active-high
//   we/re  : CPU write / read strobes
//   addr   : CPU byte address; only addr[10:2] (word index) is decoded
//   wdata  : CPU write data
//   wmask  : CPU byte enables; bit n enables wdata[8n+7:8n]
//   rdata  : CPU read data, registered, updates only when re=1
//   vaddr  : VGA word index; all 32 bits are compared against WORDS
//   vdata  : VGA read data, registered, updates every cycle
//   busy   : fill engine active
//
// Fill engine states
//   state  | meaning
//   S_IDLE | frame RAM writable by the CPU; waits for a start command
//   S_FILL | writes {4{fill_byte}} to word ptr each cycle; CPU writes dropped

module vram_ctrl #(
   parameter int WORDS          = 300,
   parameter int FILL_WORD_ADDR = 511
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic        re,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wmask,
   output logic [31:0] rdata,
   input  logic [31:0] vaddr,
   output logic [31:0] vdata,
   output logic        busy
);

   localparam logic [8:0]  WORDS9  = 9'(WORDS);
   localparam logic [8:0]  LAST9   = 9'(WORDS - 1);
   localparam logic [8:0]  CTRL9   = 9'(FILL_WORD_ADDR);
   localparam logic [31:0] WORDS32 = 32'(WORDS);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   logic [31:0] mem [WORDS];

   state_t      state_q, state_d;
   logic [8:0]  ptr_q, ptr_d;
   logic [7:0]  fill_byte_q, fill_byte_d;
   logic        busy_q, busy_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] vdata_q, vdata_d;

   logic [8:0]  idx;
   logic        is_frame;
   logic        is_ctrl;
   logic        start_cmd;
   logic        fill_wr;
   logic        cpu_wr;
   logic        unused_addr_bits;

   // The upstream bus decoder owns the remaining address bits.
   assign unused_addr_bits = ^{addr[31:11], addr[1:0]};

   assign idx       = addr[10:2];
   assign is_frame  = (idx < WORDS9);
   assign is_ctrl   = (idx == CTRL9);
   assign start_cmd = we && is_ctrl && wdata[0];
   assign fill_wr   = (state_q == S_FILL);
   // The fill engine owns the write port whenever it runs.
   assign cpu_wr    = we && is_frame && !busy_q;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      fill_byte_d = fill_byte_q;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            if (start_cmd) begin
               state_d     = S_FILL;
               ptr_d       = '0;
               fill_byte_d = wdata[15:8];
               busy_d      = 1'b1;
            end
         end
         S_FILL: begin
            // A start command here is ignored; the running fill completes.
            if (ptr_q == LAST9) begin
               state_d = S_IDLE;
               ptr_d   = '0;
               busy_d  = 1'b0;
            end else begin
               ptr_d = ptr_q + 9'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         if (is_frame) begin
            rdata_d = mem[idx];
         end else if (is_ctrl) begin
            rdata_d = {16'b0, fill_byte_q, 7'b0, busy_q};
         end else begin
            rdata_d = '0;
         end
      end
   end

   always_comb begin
      vdata_d = '0;
      if (vaddr < WORDS32) begin
         vdata_d = mem[vaddr[8:0]];
      end
   end

   // Reset lands in S_FILL so the frame is cleared once reset releases.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_FILL;
         ptr_q       <= '0;
         fill_byte_q <= 8'h00;
         busy_q      <= 1'b1;
         rdata_q     <= '0;
         vdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         fill_byte_q <= fill_byte_d;
         busy_q      <= busy_d;
         rdata_q     <= rdata_d;
         vdata_q     <= vdata_d;
      end
   end

   // Reads above use the pre-edge contents, so a same-cycle read of a
   // written word returns the old value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (fill_wr) begin
            mem[ptr_q] <= {4{fill_byte_q}};
         end else if (cpu_wr) begin
            for (int n = 0; n < 4; n++) begin
               if (wmask[n]) begin
                  mem[idx][8*n +: 8] <= wdata[8*n +: 8];
               end
            end
         end
      end
   end

   assign rdata = rdata_q;
   assign vdata = vdata_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_vram_ctrl.sv
// Directed bench for vram_ctrl: table-driven single-cycle vectors plus
// hand-written sequences for reset clear, fills and reset during a fill.

module tb_vram_ctrl;

   logic        clk;
   logic        reset;
   logic        we;
   logic        re;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic [31:0] rdata;
   logic [31:0] vaddr;
   logic [31:0] vdata;
   logic        busy;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] CTRL_ADDR = 32'h0000_07FC;

   vram_ctrl #(.WORDS(300), .FILL_WORD_ADDR(511)) dut (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .re    (re),
      .addr  (addr),
      .wdata (wdata),
      .wmask (wmask),
      .rdata (rdata),
      .vaddr (vaddr),
      .vdata (vdata),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] vaddr;
      logic        chk_r;
      logic [31:0] exp_r;
      logic        chk_v;
      logic [31:0] exp_v;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic add(input logic w, input logic r, input int word, input logic [31:0] d,
                      input logic [3:0] m, input logic [31:0] va,
                      input logic cr, input logic [31:0] er,
                      input logic cv, input logic [31:0] ev);
      vec_t v;
      v.we = w; v.re = r; v.addr = 32'(word) << 2; v.wdata = d; v.wmask = m;
      v.vaddr = va; v.chk_r = cr; v.exp_r = er; v.chk_v = cv; v.exp_v = ev;
      vq.push_back(v);
   endtask

   task automatic idle_inputs();
      we = 1'b0; re = 1'b0; addr = '0; wdata = '0; wmask = '0; vaddr = '0;
   endtask

   // Applies vq[lo..hi], one vector per clock, checking after the edge.
   task automatic apply_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         we = vq[i].we; re = vq[i].re; addr = vq[i].addr; wdata = vq[i].wdata;
         wmask = vq[i].wmask; vaddr = vq[i].vaddr;
         @(negedge clk);
         if (vq[i].chk_r) check($sformatf("vec%0d rdata", i), rdata, vq[i].exp_r);
         if (vq[i].chk_v) check($sformatf("vec%0d vdata", i), vdata, vq[i].exp_v);
      end
      idle_inputs();
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic start_fill(input logic [7:0] b);
      we = 1'b1; addr = CTRL_ADDR; wdata = {16'h0, b, 8'h01}; wmask = 4'hF;
      @(negedge clk);
      idle_inputs();
      check("busy after start", {31'b0, busy}, 32'd1);
   endtask

   task automatic run_fill(input logic [7:0] b);
      int n;
      start_fill(b);
      wait_idle(n);
      check("fill busy cycles", n, 300);
   endtask

   int cycles;

   initial begin
      idle_inputs();
      reset = 1'b1;

      // Table A: basic access after the post-reset clear.
      add(0, 1,   0, 32'h0,        4'h0, 0, 1, 32'h0,        0, 0);
      add(0, 1, 150, 32'h0,        4'h0, 0, 1, 32'h0,        0, 0);
      add(0, 1, 299, 32'h0,        4'h0, 0, 1, 32'h0,        0, 0);
      add(1, 0,   5, 32'hA1B2C3D4, 4'hF, 0, 0, 0,            0, 0);
      add(1, 0,   5, 32'h11223344, 4'h5, 0, 0, 0,            0, 0);
      add(0, 1,   5, 32'h0,        4'h0, 5, 1, 32'hA122C344, 1, 32'hA122C344);
      add(1, 0,   5, 32'h0,        4'h0, 0, 0, 0,            0, 0);
      add(0, 1,   5, 32'h0,        4'h0, 0, 1, 32'hA122C344, 0, 0);
      add(1, 1,   7, 32'hFFFFFFFF, 4'hF, 0, 1, 32'h0,        0, 0);
      add(0, 1,   7, 32'h0,        4'h0, 0, 1, 32'hFFFFFFFF, 0, 0);
      add(0, 0,   0, 32'h0,        4'h0, 0, 1, 32'hFFFFFFFF, 0, 0);
      add(1, 0, 400, 32'h12345678, 4'hF, 0, 0, 0,            0, 0);
      add(0, 1, 400, 32'h0,        4'h0, 400, 1, 32'h0,      1, 32'h0);
      add(0, 1, 511, 32'h0,        4'h0, 7, 1, 32'h0,        1, 32'hFFFFFFFF);
      add(0, 1,   0, 32'h0,        4'h0, 0, 1, 32'h0,        1, 32'h0);
      // Table B: VGA port after a 0x55 fill (index 15..).
      add(0, 0,   0, 32'h0, 4'h0, 0,            0, 0, 1, 32'h55555555);
      add(0, 0,   0, 32'h0, 4'h0, 299,          0, 0, 1, 32'h55555555);
      add(0, 0,   0, 32'h0, 4'h0, 300,          0, 0, 1, 32'h0);
      add(0, 0,   0, 32'h0, 4'h0, 1330,         0, 0, 1, 32'h0);
      add(0, 0,   0, 32'h0, 4'h0, 512,          0, 0, 1, 32'h0);
      add(0, 0,   0, 32'h0, 4'h0, 32'h1000_0005, 0, 0, 1, 32'h0);
      add(0, 1, 511, 32'h0, 4'h0, 150,          1, 32'h00005500, 1, 32'h55555555);

      // Reset held 3 cycles, then the automatic clear.
      repeat (3) begin
         @(negedge clk);
         check("reset busy", {31'b0, busy}, 32'd1);
         check("reset rdata", rdata, 32'h0);
         check("reset vdata", vdata, 32'h0);
      end
      reset = 1'b0;
      wait_idle(cycles);
      check("post-reset clear cycles", cycles, 300);

      apply_range(0, 14);

      // 0x41 fill with a dropped CPU write, status read and ignored restart.
      start_fill(8'h41);
      cycles = 0;
      while (busy && cycles < 1000) begin
         idle_inputs();
         if (cycles == 20) begin
            we = 1'b1; addr = 32'd10 << 2; wdata = 32'hDEADBEEF; wmask = 4'hF;
         end
         if (cycles == 30) begin
            re = 1'b1; addr = CTRL_ADDR;
         end
         if (cycles == 40) begin
            we = 1'b1; addr = CTRL_ADDR; wdata = 32'h0000_0701; wmask = 4'hF;
         end
         @(negedge clk);
         cycles++;
         if (cycles == 31) check("status during fill", rdata, 32'h00004101);
      end
      idle_inputs();
      check("fill 0x41 busy cycles", cycles, 300);
      for (int i = 0; i < 300; i++) begin
         re = 1'b1; addr = 32'(i) << 2;
         @(negedge clk);
         check($sformatf("word %0d after 0x41 fill", i), rdata, 32'h41414141);
      end
      re = 1'b1; addr = CTRL_ADDR;
      @(negedge clk);
      check("status after fill", rdata, 32'h00004100);
      idle_inputs();

      run_fill(8'h55);
      apply_range(15, 21);

      // Reset at fill word 120 restarts a clear from word 0.
      start_fill(8'h41);
      repeat (120) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("mid-fill reset busy", {31'b0, busy}, 32'd1);
      check("mid-fill reset vdata", vdata, 32'h0);
      reset = 1'b0;
      wait_idle(cycles);
      check("restart clear cycles", cycles, 300);
      for (int i = 0; i < 300; i++) begin
         vaddr = 32'(i);
         @(negedge clk);
         check($sformatf("vga word %0d after restart", i), vdata, 32'h0);
      end
      re = 1'b1; addr = CTRL_ADDR;
      @(negedge clk);
      check("status after restart", rdata, 32'h00000000);
      idle_inputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vram_ctrl.md
# vram_ctrl

Video RAM controller that sits directly upstream of the VGA scan-out block. It holds the 40x30 character-cell frame as 300 32-bit words (one byte per cell, four cells per word, byte 0 = leftmost cell). The CPU data bus reads and writes it with byte masks. The VGA block fetches words through a dedicated read port. A hardware fill engine clears or fills the whole frame after reset and on CPU command.

## Interface
Parameters:
- `WORDS`, 300: frame size in 32-bit words.
- `FILL_WORD_ADDR`, 511: word index of the control/status register.

Ports:
- `clk`  in  1  single system clock; VGA and CPU sides share it.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  CPU write strobe, one word per cycle.
- `re`  in  1  CPU read strobe.
- `addr`  in  32  CPU byte address. Only `addr[10:2]` (word index) is decoded; the upstream bus decoder owns the upper bits.
- `wdata`  in  32  CPU write data.
- `wmask`  in  4  CPU byte enables; bit n enables `wdata[8n+7:8n]`.
- `rdata`  out  32  CPU read data, registered.
- `vaddr`  in  32  VGA word index.
- `vdata`  out  32  VGA read data, registered.
- `busy`  out  1  fill engine active.

## Operation
Word map (`addr[10:2]`):
- 0..299: frame RAM.
- 300..510: unmapped. Writes are ignored; reads return 0.
- 511: control/status register.
  - Write with `wdata[0]`=1 starts a fill with byte `wdata[15:8]`.
  - Read returns `{16'b0, fill_byte[7:0], 7'b0, busy}`.

Fill engine FSM:
- States: IDLE and FILL. Registers: `ptr[8:0]` and `fill_byte[7:0]`.
- IDLE -> FILL on a control write with `wdata[0]`=1. This loads `ptr`=0 and `fill_byte`=`wdata[15:8]`.
- In FILL, each cycle writes `{4{fill_byte}}` to word `ptr`, then increments `ptr`.
- The write at `ptr`=`WORDS`-1 returns the FSM to IDLE.
- A start command while in FILL is ignored; the fill is not restarted.

CPU writes:
- A frame-RAM write takes effect only when `busy`=0. Writes while `busy`=1 are dropped with no retry; software polls `busy`.
- Masked bytes are preserved. `wmask`=0 is a no-op.

CPU reads:
- Allowed at any time, including during a fill, and return current RAM contents.
- `rdata` updates only on cycles with `re`=1 and holds otherwise.

`we`=`re`=1 on the same word: `rdata` gets the pre-write value (read-before-write), and the write still happens.

VGA port:
- Every cycle, `vdata` <= RAM[`vaddr`] if `vaddr` < `WORDS`, else 0.
- The full 32 bits of `vaddr` are compared, so scan positions in blanking (index up to ~1330) read 0.
- No enable; the port never stalls.

Reset:
- `state` <= FILL, `ptr` <= 0, `fill_byte` <= 0x00, `busy` <= 1, `rdata` <= 0, `vdata` <= 0.
- RAM writes are suppressed while `reset`=1.
- The engine therefore clears the frame to 0x00 after reset.
- Reset asserted during any fill aborts it and restarts the clear from word 0.

## Timing
- CPU read latency: 1 cycle. `rdata` is valid on the edge after the `re` cycle.
- VGA read latency: 1 cycle. This matches the scan-out block's 2-stage display-enable pipeline, in which the address is set from the counters one cycle before use.
- CPU write: RAM updated at the edge of the `we` cycle. A read of the same word on the next cycle returns the new data.
- Fill start: a control write at edge T gives `busy`=1 after T. Word k is written at edge T+1+k. `busy`=0 after edge T+300.
- After reset: the first clear write is at the first edge with `reset`=0. `busy` falls 300 edges after reset deasserts.
- The CPU write port and the fill engine share the RAM write port; the fill engine always wins.
- The VGA read port is independent and never blocked.

## Test plan
- Reset held 3 cycles then released -> `busy`=1 for exactly 300 cycles. Afterwards, CPU reads of words 0, 150 and 299 return 0x00000000; `rdata`=0 and `vdata`=0 during reset.
- CPU write word 5 = 0xA1B2C3D4 with `wmask`=1111, then `wmask`=0101 with `wdata`=0x11223344 -> read word 5 returns 0xA122C344 one cycle after `re`.
- Control write `wdata`=0x00004101 -> `busy` high 300 cycles. During the fill, a write to word 10 is dropped. After the fill, every word reads 0x41414141, and status reads 0x00004100.
- `vaddr` sequence 0, 299, 300, 1330 after filling with 0x55 -> `vdata` one cycle later is 0x55555555, 0x55555555, 0, 0.
- `we`=`re`=1 on word 7 (old 0x00000000, new 0xFFFFFFFF) -> `rdata`=0x00000000; the next read returns 0xFFFFFFFF. Writes and reads at word 400 are ignored and return 0.
- `reset` pulsed at fill word 120 of a 0x41 fill -> the fill restarts with 0x00, `busy` stays high 300 cycles after release, and the final frame is all zero.
